// File: rtl/pipe_decode_ctrl_if.sv
// Handshake and control-bundle bus between IF/ID, the decoder and ID/EX.
// The slave side is the decoder; the master side is the pipeline around it.
interface pipe_decode_ctrl_if #(
   parameter int ALU_OP_W = 4
) ();
   logic                i_valid;
   logic [5:0]          i_op;
   logic [5:0]          i_func;
   logic                i_stall;
   logic                i_flush;
   logic                i_resume;

   logic                o_ready;
   logic                o_valid;
   logic                o_reg_write;
   logic                o_mem_write;
   logic                o_mem_to_reg;
   logic                o_alu_src_b;
   logic                o_reg_dst;
   logic                o_signed_ext;
   logic                o_beq;
   logic                o_bne;
   logic                o_bltz;
   logic                o_jmp;
   logic                o_jal;
   logic                o_jr;
   logic                o_syscall;
   logic                o_ram_type;
   logic [ALU_OP_W-1:0] o_alu_op;
   logic                o_md_start;
   logic [1:0]          o_hilo_sel;
   logic                o_illegal;
   logic                o_md_busy;
   logic                o_halted;

   modport slave (
      input  i_valid, i_op, i_func, i_stall, i_flush, i_resume,
      output o_ready, o_valid, o_reg_write, o_mem_write, o_mem_to_reg,
             o_alu_src_b, o_reg_dst, o_signed_ext, o_beq, o_bne, o_bltz,
             o_jmp, o_jal, o_jr, o_syscall, o_ram_type, o_alu_op,
             o_md_start, o_hilo_sel, o_illegal, o_md_busy, o_halted
   );

   modport master (
      output i_valid, i_op, i_func, i_stall, i_flush, i_resume,
      input  o_ready, o_valid, o_reg_write, o_mem_write, o_mem_to_reg,
             o_alu_src_b, o_reg_dst, o_signed_ext, o_beq, o_bne, o_bltz,
             o_jmp, o_jal, o_jr, o_syscall, o_ram_type, o_alu_op,
             o_md_start, o_hilo_sel, o_illegal, o_md_busy, o_halted
   );
endinterface

// File: rtl/pipe_decode_ctrl.sv
// Registered MIPS control decoder with valid/ready handshake, HI/LO
// multi-cycle interlock and SYSCALL halt/resume sequencing.
module pipe_decode_ctrl #(
   parameter int MD_LATENCY      = 8,
   parameter bit HALT_ON_SYSCALL = 1'b1,
   parameter int ALU_OP_W        = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   pipe_decode_ctrl_if.slave  bus
);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_MD_BUSY = 2'd1;
   localparam logic [1:0] ST_HALT    = 2'd2;

   localparam logic [5:0] MD_LOAD = 6'(MD_LATENCY - 1);

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_BLTZ  = 6'd1;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_ADDIU = 6'd9;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_SLTIU = 6'd11;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_XORI  = 6'd14;
   localparam logic [5:0] OP_LH    = 6'd33;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [5:0] F_SLL     = 6'd0;
   localparam logic [5:0] F_SRL     = 6'd2;
   localparam logic [5:0] F_SRA     = 6'd3;
   localparam logic [5:0] F_JR      = 6'd8;
   localparam logic [5:0] F_SYSCALL = 6'd12;
   localparam logic [5:0] F_MFHI    = 6'd16;
   localparam logic [5:0] F_MFLO    = 6'd18;
   localparam logic [5:0] F_MULT    = 6'd24;
   localparam logic [5:0] F_MULTU   = 6'd25;
   localparam logic [5:0] F_DIV     = 6'd26;
   localparam logic [5:0] F_DIVU    = 6'd27;
   localparam logic [5:0] F_ADD     = 6'd32;
   localparam logic [5:0] F_ADDU    = 6'd33;
   localparam logic [5:0] F_SUB     = 6'd34;
   localparam logic [5:0] F_AND     = 6'd36;
   localparam logic [5:0] F_OR      = 6'd37;
   localparam logic [5:0] F_NOR     = 6'd39;
   localparam logic [5:0] F_SLT     = 6'd42;
   localparam logic [5:0] F_SLTU    = 6'd43;

   localparam logic [3:0] ALU_SLL  = 4'd0;
   localparam logic [3:0] ALU_SRA  = 4'd1;
   localparam logic [3:0] ALU_SRL  = 4'd2;
   localparam logic [3:0] ALU_ADD  = 4'd5;
   localparam logic [3:0] ALU_SUB  = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_XOR  = 4'd9;
   localparam logic [3:0] ALU_NOR  = 4'd10;
   localparam logic [3:0] ALU_SLT  = 4'd11;
   localparam logic [3:0] ALU_SLTU = 4'd12;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src_b;
      logic       reg_dst;
      logic       signed_ext;
      logic       beq;
      logic       bne;
      logic       bltz;
      logic       jmp;
      logic       jal;
      logic       jr;
      logic       syscall;
      logic       ram_type;
      logic [3:0] alu_op;
      logic       md_start;
      logic [1:0] hilo_sel;
      logic       illegal;
   } ctrl_t;

   ctrl_t      w_dec;
   logic       w_r_alu;
   logic       w_i_alu;
   logic       w_load;
   logic       w_known;
   logic       w_hilo_dep;
   logic       w_ready;
   logic       w_accept;
   logic       w_take;
   logic [1:0] w_state_next;

   ctrl_t      r_bndl;
   logic       r_valid;
   logic [1:0] r_state;
   logic [5:0] r_md_cnt;
   logic       r_md_pend;

   // Instructions are first sorted into classes; shared control bits are
   // then derived from the class so each opcode only lists what is unique.
   always_comb begin
      w_dec   = '0;
      w_r_alu = 1'b0;
      w_i_alu = 1'b0;
      w_load  = 1'b0;
      w_known = 1'b1;
      case (bus.i_op)
         OP_RTYPE: begin
            case (bus.i_func)
               F_SLL:   begin w_r_alu = 1'b1; w_dec.alu_op = ALU_SLL;  end
               F_SRA:   begin w_r_alu = 1'b1; w_dec.alu_op = ALU_SRA;  end
               F_SRL:   begin w_r_alu = 1'b1; w_dec.alu_op = ALU_SRL;  end
               F_ADD,
               F_ADDU:  begin w_r_alu = 1'b1; w_dec.alu_op = ALU_ADD;  end
               F_SUB:   begin w_r_alu = 1'b1; w_dec.alu_op = ALU_SUB;  end
               F_AND:   begin w_r_alu = 1'b1; w_dec.alu_op = ALU_AND;  end
               F_OR:    begin w_r_alu = 1'b1; w_dec.alu_op = ALU_OR;   end
               F_NOR:   begin w_r_alu = 1'b1; w_dec.alu_op = ALU_NOR;  end
               F_SLT:   begin w_r_alu = 1'b1; w_dec.alu_op = ALU_SLT;  end
               F_SLTU:  begin w_r_alu = 1'b1; w_dec.alu_op = ALU_SLTU; end
               F_JR:      w_dec.jr      = 1'b1;
               F_SYSCALL: w_dec.syscall = 1'b1;
               F_MFHI: begin
                  w_dec.reg_write = 1'b1;
                  w_dec.reg_dst   = 1'b1;
                  w_dec.hilo_sel  = 2'b01;
               end
               F_MFLO: begin
                  w_dec.reg_write = 1'b1;
                  w_dec.reg_dst   = 1'b1;
                  w_dec.hilo_sel  = 2'b10;
               end
               F_MULT, F_MULTU, F_DIV, F_DIVU: w_dec.md_start = 1'b1;
               default: w_known = 1'b0;
            endcase
         end
         OP_J:    w_dec.jmp = 1'b1;
         OP_JAL: begin
            w_dec.jal       = 1'b1;
            w_dec.reg_write = 1'b1;
         end
         OP_BEQ:  begin w_dec.beq = 1'b1; w_dec.signed_ext = 1'b1; end
         OP_BNE:  begin w_dec.bne = 1'b1; w_dec.signed_ext = 1'b1; end
         OP_BLTZ: begin
            w_dec.bltz       = 1'b1;
            w_dec.signed_ext = 1'b1;
            w_dec.alu_op     = ALU_SLT;
         end
         OP_ADDI:  begin w_i_alu = 1'b1; w_dec.signed_ext = 1'b1; w_dec.alu_op = ALU_ADD;  end
         OP_ADDIU: begin w_i_alu = 1'b1; w_dec.alu_op = ALU_ADD;  end
         OP_SLTI:  begin w_i_alu = 1'b1; w_dec.signed_ext = 1'b1; w_dec.alu_op = ALU_SLT;  end
         OP_SLTIU: begin w_i_alu = 1'b1; w_dec.signed_ext = 1'b1; w_dec.alu_op = ALU_SLTU; end
         OP_ANDI:  begin w_i_alu = 1'b1; w_dec.alu_op = ALU_AND;  end
         OP_ORI:   begin w_i_alu = 1'b1; w_dec.alu_op = ALU_OR;   end
         OP_XORI:  begin w_i_alu = 1'b1; w_dec.alu_op = ALU_XOR;  end
         OP_LW:    w_load = 1'b1;
         OP_LH: begin
            w_load         = 1'b1;
            w_dec.ram_type = 1'b1;
         end
         OP_SW: begin
            w_dec.mem_write  = 1'b1;
            w_dec.alu_src_b  = 1'b1;
            w_dec.signed_ext = 1'b1;
            w_dec.alu_op     = ALU_ADD;
         end
         default: w_known = 1'b0;
      endcase

      if (w_r_alu) begin
         w_dec.reg_write = 1'b1;
         w_dec.reg_dst   = 1'b1;
      end
      if (w_i_alu || w_load) begin
         w_dec.reg_write = 1'b1;
         w_dec.alu_src_b = 1'b1;
      end
      if (w_load) begin
         w_dec.mem_to_reg = 1'b1;
         w_dec.signed_ext = 1'b1;
         w_dec.alu_op     = ALU_ADD;
      end
      if (!w_known) begin
         w_dec         = '0;
         w_dec.illegal = 1'b1;
      end
   end

   // Anything touching HI/LO must wait while the multiply/divide unit runs.
   assign w_hilo_dep = w_dec.md_start | (w_dec.hilo_sel != 2'b00);
   assign w_ready    = !bus.i_stall && (r_state != ST_HALT) &&
                       !((r_state == ST_MD_BUSY) && w_hilo_dep);
   assign w_accept   = bus.i_valid && w_ready;
   assign w_take     = w_accept && !bus.i_flush;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_take && w_dec.syscall && HALT_ON_SYSCALL)
               w_state_next = ST_HALT;
            else if (w_take && w_dec.md_start)
               w_state_next = ST_MD_BUSY;
         end
         ST_MD_BUSY: begin
            if (w_take && w_dec.syscall && HALT_ON_SYSCALL)
               w_state_next = ST_HALT;
            else if (r_md_cnt == 6'd0)
               w_state_next = ST_RUN;
         end
         ST_HALT: begin
            if (bus.i_resume)
               w_state_next = (r_md_pend && (r_md_cnt != 6'd0)) ? ST_MD_BUSY : ST_RUN;
         end
         default: w_state_next = ST_RUN;
      endcase
   end

   // The HI/LO countdown runs regardless of stall, flush or halt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_RUN;
         r_md_cnt  <= 6'd0;
         r_md_pend <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (r_md_pend) begin
            if (r_md_cnt == 6'd0)
               r_md_pend <= 1'b0;
            else
               r_md_cnt <= r_md_cnt - 6'd1;
         end
         if (w_take && w_dec.md_start) begin
            r_md_pend <= 1'b1;
            r_md_cnt  <= MD_LOAD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_bndl  <= '0;
      end else if (bus.i_flush) begin
         r_valid <= 1'b0;
         r_bndl  <= '0;
      end else if (bus.i_stall) begin
         r_valid <= r_valid;
         r_bndl  <= r_bndl;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_bndl  <= w_dec;
      end else begin
         r_valid <= 1'b0;
         r_bndl  <= '0;
      end
   end

   assign bus.o_ready      = w_ready;
   assign bus.o_valid      = r_valid;
   assign bus.o_reg_write  = r_bndl.reg_write;
   assign bus.o_mem_write  = r_bndl.mem_write;
   assign bus.o_mem_to_reg = r_bndl.mem_to_reg;
   assign bus.o_alu_src_b  = r_bndl.alu_src_b;
   assign bus.o_reg_dst    = r_bndl.reg_dst;
   assign bus.o_signed_ext = r_bndl.signed_ext;
   assign bus.o_beq        = r_bndl.beq;
   assign bus.o_bne        = r_bndl.bne;
   assign bus.o_bltz       = r_bndl.bltz;
   assign bus.o_jmp        = r_bndl.jmp;
   assign bus.o_jal        = r_bndl.jal;
   assign bus.o_jr         = r_bndl.jr;
   assign bus.o_syscall    = r_bndl.syscall;
   assign bus.o_ram_type   = r_bndl.ram_type;
   assign bus.o_alu_op     = ALU_OP_W'(r_bndl.alu_op);
   assign bus.o_md_start   = r_bndl.md_start;
   assign bus.o_hilo_sel   = r_bndl.hilo_sel;
   assign bus.o_illegal    = r_bndl.illegal;
   assign bus.o_md_busy    = r_md_pend;
   assign bus.o_halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Directed bench for pipe_decode_ctrl: expected bundles are queued when an
// instruction is accepted and compared when the output register updates.
module tb_pipe_decode_ctrl;

   typedef struct packed {
      logic       rw;
      logic       mw;
      logic       m2r;
      logic       asb;
      logic       rdst;
      logic       sext;
      logic       beq;
      logic       bne;
      logic       bltz;
      logic       jmp;
      logic       jal;
      logic       jr;
      logic       sys;
      logic       ramt;
      logic [3:0] alu;
      logic       mds;
      logic [1:0] hilo;
      logic       ill;
   } bundle_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipe_decode_ctrl_if #(.ALU_OP_W(4)) bus ();

   pipe_decode_ctrl #(
      .MD_LATENCY      (8),
      .HALT_ON_SYSCALL (1'b1),
      .ALU_OP_W        (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int      total = 0;
   int      bad   = 0;
   bundle_t sb_q[$];
   bundle_t exp_b;
   logic    exp_v;

   function automatic bundle_t observed();
      bundle_t b;
      b = {bus.o_reg_write, bus.o_mem_write, bus.o_mem_to_reg, bus.o_alu_src_b,
           bus.o_reg_dst, bus.o_signed_ext, bus.o_beq, bus.o_bne, bus.o_bltz,
           bus.o_jmp, bus.o_jal, bus.o_jr, bus.o_syscall, bus.o_ram_type,
           bus.o_alu_op, bus.o_md_start, bus.o_hilo_sel, bus.o_illegal};
      return b;
   endfunction

   // Reference decode written per instruction from the control table.
   function automatic bundle_t ref_dec(input logic [5:0] op, input logic [5:0] fn);
      bundle_t b;
      b = '0;
      if (op == 6'd0) begin
         case (fn)
            6'd0:  begin b.rw = 1; b.rdst = 1; b.alu = 4'd0;  end
            6'd3:  begin b.rw = 1; b.rdst = 1; b.alu = 4'd1;  end
            6'd2:  begin b.rw = 1; b.rdst = 1; b.alu = 4'd2;  end
            6'd32: begin b.rw = 1; b.rdst = 1; b.alu = 4'd5;  end
            6'd33: begin b.rw = 1; b.rdst = 1; b.alu = 4'd5;  end
            6'd34: begin b.rw = 1; b.rdst = 1; b.alu = 4'd6;  end
            6'd36: begin b.rw = 1; b.rdst = 1; b.alu = 4'd7;  end
            6'd37: begin b.rw = 1; b.rdst = 1; b.alu = 4'd8;  end
            6'd39: begin b.rw = 1; b.rdst = 1; b.alu = 4'd10; end
            6'd42: begin b.rw = 1; b.rdst = 1; b.alu = 4'd11; end
            6'd43: begin b.rw = 1; b.rdst = 1; b.alu = 4'd12; end
            6'd8:  b.jr = 1;
            6'd12: b.sys = 1;
            6'd16: begin b.rw = 1; b.rdst = 1; b.hilo = 2'b01; end
            6'd18: begin b.rw = 1; b.rdst = 1; b.hilo = 2'b10; end
            6'd24, 6'd25, 6'd26, 6'd27: b.mds = 1;
            default: b.ill = 1;
         endcase
      end else begin
         case (op)
            6'd2:  b.jmp = 1;
            6'd3:  begin b.jal = 1; b.rw = 1; end
            6'd4:  begin b.beq = 1; b.sext = 1; end
            6'd5:  begin b.bne = 1; b.sext = 1; end
            6'd1:  begin b.bltz = 1; b.sext = 1; b.alu = 4'd11; end
            6'd8:  begin b.rw = 1; b.asb = 1; b.sext = 1; b.alu = 4'd5;  end
            6'd9:  begin b.rw = 1; b.asb = 1; b.alu = 4'd5;  end
            6'd10: begin b.rw = 1; b.asb = 1; b.sext = 1; b.alu = 4'd11; end
            6'd11: begin b.rw = 1; b.asb = 1; b.sext = 1; b.alu = 4'd12; end
            6'd12: begin b.rw = 1; b.asb = 1; b.alu = 4'd7;  end
            6'd13: begin b.rw = 1; b.asb = 1; b.alu = 4'd8;  end
            6'd14: begin b.rw = 1; b.asb = 1; b.alu = 4'd9;  end
            6'd35: begin b.rw = 1; b.asb = 1; b.m2r = 1; b.sext = 1; b.alu = 4'd5; end
            6'd33: begin b.rw = 1; b.asb = 1; b.m2r = 1; b.sext = 1; b.alu = 4'd5; b.ramt = 1; end
            6'd43: begin b.mw = 1; b.asb = 1; b.sext = 1; b.alu = 4'd5; end
            default: b.ill = 1;
         endcase
      end
      return b;
   endfunction

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check_bndl(input string tag, input bundle_t obs, input bundle_t exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic e_busy, input logic e_halt);
      check_bit({tag, ".valid"}, bus.o_valid, exp_v);
      check_bndl({tag, ".bundle"}, observed(), exp_b);
      check_bit({tag, ".md_busy"}, bus.o_md_busy, e_busy);
      check_bit({tag, ".halted"}, bus.o_halted, e_halt);
   endtask

   // One clock: drive, check ready, edge, then check the registered result.
   task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic st, input logic fl, input logic rs,
                       input logic e_rdy, input logic e_busy, input logic e_halt,
                       input string tag);
      bus.i_valid  = v;
      bus.i_op     = op;
      bus.i_func   = fn;
      bus.i_stall  = st;
      bus.i_flush  = fl;
      bus.i_resume = rs;
      #1;
      check_bit({tag, ".ready"}, bus.o_ready, e_rdy);
      if (v && e_rdy && !fl)
         sb_q.push_back(ref_dec(op, fn));
      @(posedge clk);
      #1;
      if (fl) begin
         exp_v = 1'b0;
         exp_b = '0;
      end else if (st) begin
         exp_v = exp_v;
      end else if (v && e_rdy) begin
         total++;
         assert (sb_q.size() > 0) else begin
            bad++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
         end
         exp_v = 1'b1;
         exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      end else begin
         exp_v = 1'b0;
         exp_b = '0;
      end
      check_all(tag, e_busy, e_halt);
      $display("step %-14s op=%0d func=%0d v=%0b st=%0b fl=%0b rs=%0b -> out_valid=%0b bundle=%06h busy=%0b halted=%0b",
               tag, op, fn, v, st, fl, rs, bus.o_valid, observed(), bus.o_md_busy, bus.o_halted);
   endtask

   logic [11:0] dec_tbl [26];

   initial begin
      bus.i_valid  = 1'b0;
      bus.i_op     = 6'd0;
      bus.i_func   = 6'd0;
      bus.i_stall  = 1'b0;
      bus.i_flush  = 1'b0;
      bus.i_resume = 1'b0;
      exp_v = 1'b0;
      exp_b = '0;
      dec_tbl = '{{6'd0, 6'd0},  {6'd0, 6'd2},  {6'd0, 6'd3},  {6'd0, 6'd34},
                  {6'd0, 6'd36}, {6'd0, 6'd37}, {6'd0, 6'd39}, {6'd0, 6'd42},
                  {6'd0, 6'd43}, {6'd0, 6'd33}, {6'd0, 6'd8},  {6'd2, 6'd0},
                  {6'd3, 6'd0},  {6'd4, 6'd0},  {6'd5, 6'd0},  {6'd1, 6'd0},
                  {6'd9, 6'd0},  {6'd10, 6'd0}, {6'd11, 6'd0}, {6'd12, 6'd0},
                  {6'd13, 6'd0}, {6'd14, 6'd0}, {6'd33, 6'd0}, {6'd43, 6'd0},
                  {6'd0, 6'd63}, {6'd63, 6'd0}};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 1'b0, 1'b0);
      check_bit("reset.ready", bus.o_ready, 1'b1);
      rst_n = 1'b1;

      // Basic decode
      step(1, 6'd0, 6'd32, 0, 0, 0, 1, 0, 0, "add");
      step(0, 6'd0, 6'd0,  0, 0, 0, 1, 0, 0, "bubble");

      // MULT then MFLO waiting on the HI/LO interlock
      step(1, 6'd0, 6'd24, 0, 0, 0, 1, 1, 0, "mult");
      for (int k = 1; k <= 8; k++)
         step(1, 6'd0, 6'd18, 0, 0, 0, 0, (k < 8), 0, "mflo_wait");
      step(1, 6'd0, 6'd18, 0, 0, 0, 1, 0, 0, "mflo");
      step(0, 6'd0, 6'd0,  0, 0, 0, 1, 0, 0, "bubble");

      // LW frozen by stall
      step(1, 6'd35, 6'd0, 0, 0, 0, 1, 0, 0, "lw");
      for (int k = 0; k < 3; k++)
         step(1, 6'd8, 6'd0, 1, 0, 0, 0, 0, 0, "lw_stall");
      step(1, 6'd8, 6'd0, 0, 0, 0, 1, 0, 0, "addi");

      // SYSCALL halt and resume
      step(1, 6'd0, 6'd12, 0, 0, 0, 1, 0, 1, "syscall");
      for (int k = 0; k < 2; k++)
         step(1, 6'd8, 6'd0, 0, 0, 0, 0, 0, 1, "halt_wait");
      step(1, 6'd8, 6'd0, 0, 0, 1, 0, 0, 0, "resume");
      step(1, 6'd8, 6'd0, 0, 0, 0, 1, 0, 0, "addi_after");
      step(0, 6'd0, 6'd0, 0, 0, 1, 1, 0, 0, "resume_ignored");

      // Flush priority and squashed MD op
      step(1, 6'd0, 6'd32, 0, 0, 0, 1, 0, 0, "add2");
      step(1, 6'd4, 6'd0,  1, 1, 0, 0, 0, 0, "beq_flush");
      step(1, 6'd0, 6'd24, 0, 1, 0, 1, 0, 0, "mult_flush");
      step(1, 6'd0, 6'd16, 0, 0, 0, 1, 0, 0, "mfhi");

      // SYSCALL while the HI/LO unit is busy
      step(1, 6'd0, 6'd26, 0, 0, 0, 1, 1, 0, "div");
      step(1, 6'd0, 6'd12, 0, 0, 0, 1, 1, 1, "sys_in_md");
      step(0, 6'd0, 6'd0,  0, 0, 1, 0, 1, 0, "resume_md");
      for (int k = 1; k <= 6; k++)
         step(1, 6'd0, 6'd16, 0, 0, 0, 0, (k < 6), 0, "mfhi_wait");
      step(1, 6'd0, 6'd16, 0, 0, 0, 1, 0, 0, "mfhi2");

      // Remaining decode table, back to back, including illegal encodings
      for (int i = 0; i < 26; i++) begin
         logic [11:0] e;
         e = dec_tbl[i];
         step(1, e[11:6], e[5:0], 0, 0, 0, 1, 0, 0, "decode");
      end

      // Asynchronous reset in the middle of an MD operation
      step(1, 6'd0, 6'd25, 0, 0, 0, 1, 1, 0, "multu");
      rst_n = 1'b0;
      #2;
      exp_v = 1'b0;
      exp_b = '0;
      sb_q.delete();
      check_all("async_rst", 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1, 6'd0, 6'd16, 0, 0, 0, 1, 0, 0, "mfhi_post_rst");
      step(0, 6'd0, 6'd0,  0, 0, 0, 1, 0, 0, "bubble");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
